// File: rtl/liteeth_sram_pkg.sv
// Shared types and constants for the LiteEth dual-port SRAM generator.
// Holds the controller state encoding and the legal read-latency bounds.
package liteeth_sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/liteeth_sram_rd_pipe.sv
// LATENCY-deep read-data/valid pipeline for one SRAM read port.
// Each data stage only loads when its incoming valid is set, so the output holds between reads.
module liteeth_sram_rd_pipe
  import liteeth_sram_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int LATENCY = 1
) (
  input  logic            clk0,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [BITS-1:0] data_i,
  output logic            valid_o,
  output logic [BITS-1:0] data_o
);

  if (LATENCY < RD_LAT_MIN || LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("liteeth_sram_rd_pipe: unsupported LATENCY");
  end

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [BITS-1:0]    dat_q [LATENCY];
  logic [BITS-1:0]    dat_d [LATENCY];

  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = valid_i;
    dat_d[0] = valid_i ? data_i : dat_q[0];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/liteeth_dp_sram_gen.sv
// Dual-port (RW + R) SRAM with lane write mask, read-first RW port, optional R-port bypass,
// self-clearing after reset, collision pulse and sticky out-of-range error.
module liteeth_dp_sram_gen
  import liteeth_sram_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int WORD_DEPTH   = 384,
  parameter int ADDR_WIDTH   = $clog2(WORD_DEPTH),
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                      clk0,
  input  logic                      rst_n,
  input  logic                      ce_rw,
  input  logic                      we_rw,
  input  logic [BITS/MASK_GRAN-1:0] w_mask_rw,
  input  logic [ADDR_WIDTH-1:0]     addr_rw,
  input  logic [BITS-1:0]           wd_in_rw,
  output logic [BITS-1:0]           rd_out_rw,
  output logic                      rd_valid_rw,
  input  logic                      ce_r,
  input  logic [ADDR_WIDTH-1:0]     addr_r,
  output logic [BITS-1:0]           rd_out_r,
  output logic                      rd_valid_r,
  output logic                      init_busy,
  output logic                      collision,
  output logic                      oob_err
);

  localparam int LANES = BITS / MASK_GRAN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [BITS-1:0] mem [WORD_DEPTH];

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_busy_q, init_busy_d;
  logic                  collision_q, collision_d;
  logic                  oob_q, oob_d;

  logic                  run, acc_rw, acc_r, wr, rw_ok, r_ok, same_addr;
  logic [BITS-1:0]       rw_old, merged, r_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [BITS-1:0]       mem_wd;

  always_comb begin
    run       = (state_q == ST_RUN);
    acc_rw    = run & ce_rw;
    acc_r     = run & ce_r;
    wr        = acc_rw & we_rw;
    rw_ok     = 32'(addr_rw) < WORD_DEPTH;
    r_ok      = 32'(addr_r) < WORD_DEPTH;
    same_addr = (addr_rw == addr_r);

    rw_old = rw_ok ? mem[addr_rw] : '0;
    merged = rw_old;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_mask_rw[k]) begin
        merged[k*MASK_GRAN +: MASK_GRAN] = wd_in_rw[k*MASK_GRAN +: MASK_GRAN];
      end
    end

    r_data = '0;
    if (r_ok) begin
      r_data = (BYPASS != 0 && wr && same_addr) ? merged : mem[addr_r];
    end

    // The single array write port is shared by the clear sweep and the RW port.
    mem_we = !run || (wr && rw_ok);
    mem_wa = run ? addr_rw : clr_cnt_q;
    mem_wd = run ? merged : '0;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    init_busy_d = (state_d == ST_INIT);
    collision_d = wr && acc_r && rw_ok && same_addr;
    oob_d       = oob_q || (acc_rw && !rw_ok) || (acc_r && !r_ok);
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
      collision_q <= collision_d;
      oob_q       <= oob_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  liteeth_sram_rd_pipe #(
    .BITS    (BITS),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe_rw (
    .clk0    (clk0),
    .rst_n   (rst_n),
    .valid_i (acc_rw),
    .data_i  (rw_old),
    .valid_o (rd_valid_rw),
    .data_o  (rd_out_rw)
  );

  liteeth_sram_rd_pipe #(
    .BITS    (BITS),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe_r (
    .clk0    (clk0),
    .rst_n   (rst_n),
    .valid_i (acc_r),
    .data_i  (r_data),
    .valid_o (rd_valid_r),
    .data_o  (rd_out_r)
  );

  assign init_busy = init_busy_q;
  assign collision = collision_q;
  assign oob_err   = oob_q;

endmodule

// File: tb/tb_liteeth_dp_sram_gen.sv
// Directed bench: two instances share stimulus; A uses defaults, B uses READ_LATENCY=2, BYPASS=0.
module tb_liteeth_dp_sram_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_rw, we_rw, ce_r;
  logic [3:0]  w_mask_rw;
  logic [8:0]  addr_rw, addr_r;
  logic [31:0] wd_in_rw;

  logic [31:0] a_rd_out_rw, a_rd_out_r, b_rd_out_rw, b_rd_out_r;
  logic        a_rd_valid_rw, a_rd_valid_r, a_init_busy, a_collision, a_oob_err;
  logic        b_rd_valid_rw, b_rd_valid_r, b_init_busy, b_collision, b_oob_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  liteeth_dp_sram_gen u_dut_a (
    .clk0(clk), .rst_n(rst_n), .ce_rw(ce_rw), .we_rw(we_rw), .w_mask_rw(w_mask_rw),
    .addr_rw(addr_rw), .wd_in_rw(wd_in_rw), .rd_out_rw(a_rd_out_rw), .rd_valid_rw(a_rd_valid_rw),
    .ce_r(ce_r), .addr_r(addr_r), .rd_out_r(a_rd_out_r), .rd_valid_r(a_rd_valid_r),
    .init_busy(a_init_busy), .collision(a_collision), .oob_err(a_oob_err)
  );

  liteeth_dp_sram_gen #(
    .READ_LATENCY (2),
    .BYPASS       (0)
  ) u_dut_b (
    .clk0(clk), .rst_n(rst_n), .ce_rw(ce_rw), .we_rw(we_rw), .w_mask_rw(w_mask_rw),
    .addr_rw(addr_rw), .wd_in_rw(wd_in_rw), .rd_out_rw(b_rd_out_rw), .rd_valid_rw(b_rd_valid_rw),
    .ce_r(ce_r), .addr_r(addr_r), .rd_out_r(b_rd_out_r), .rd_valid_r(b_rd_valid_r),
    .init_busy(b_init_busy), .collision(b_collision), .oob_err(b_oob_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_rw = 1'b0; we_rw = 1'b0; ce_r = 1'b0;
    w_mask_rw = 4'h0; addr_rw = '0; addr_r = '0; wd_in_rw = '0;
  endtask

  task automatic test_reset();
    logic [70:0] exp_v;
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    exp_v = {32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if ({a_rd_out_rw, a_rd_valid_rw, a_rd_out_r, a_rd_valid_r, a_init_busy, a_collision, a_oob_err} !== exp_v) begin
      n_err++;
      $display("FAIL reset_a: got %h expected %h",
               {a_rd_out_rw, a_rd_valid_rw, a_rd_out_r, a_rd_valid_r, a_init_busy, a_collision, a_oob_err}, exp_v);
    end
    n_vec++;
    if ({b_rd_out_rw, b_rd_valid_rw, b_rd_out_r, b_rd_valid_r, b_init_busy, b_collision, b_oob_err} !== exp_v) begin
      n_err++;
      $display("FAIL reset_b: got %h expected %h",
               {b_rd_out_rw, b_rd_valid_rw, b_rd_out_r, b_rd_valid_r, b_init_busy, b_collision, b_oob_err}, exp_v);
    end
  endtask

  task automatic test_init();
    int n;
    int bad;
    // Hammer both ports during the clear sweep; everything must be ignored.
    ce_rw = 1'b1; we_rw = 1'b1; w_mask_rw = 4'hF; addr_rw = 9'd9; wd_in_rw = 32'hFFFF_FFFF; ce_r = 1'b1;
    rst_n = 1'b1;
    n = 0; bad = 0;
    while (a_init_busy === 1'b1 && n < 2000) begin
      addr_r = n[0] ? 9'd400 : 9'd9;
      tick();
      n++;
      if (a_rd_valid_r | a_rd_valid_rw | a_collision | a_oob_err |
          b_rd_valid_r | b_rd_valid_rw | b_collision | b_oob_err) bad++;
    end
    idle();
    n_vec++;
    if (n !== 384) begin
      n_err++;
      $display("FAIL init_cycles: got %0d expected 384", n);
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL init_ignored: got %0d active cycles expected 0", bad);
    end
    n_vec++;
    if ({b_init_busy, a_oob_err, b_oob_err} !== 3'b000) begin
      n_err++;
      $display("FAIL init_done_flags: got %b expected 000", {b_init_busy, a_oob_err, b_oob_err});
    end
    for (int a = 0; a < 384; a++) begin
      addr_r = a[8:0]; addr_rw = a[8:0]; ce_r = 1'b1; ce_rw = 1'b1; we_rw = 1'b0;
      tick();
      n_vec++;
      if ({a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw} !== {1'b1, 32'h0, 1'b1, 32'h0} ||
          (a > 0 && {b_rd_valid_r, b_rd_out_r} !== {1'b1, 32'h0})) begin
        n_err++;
        $display("FAIL clear_scan[%0d]: got a_r=%b/%h a_rw=%b/%h b_r=%b/%h expected valid 1 data 0",
                 a, a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, b_rd_valid_r, b_rd_out_r);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_mask_write();
    ce_rw = 1'b1; we_rw = 1'b1; w_mask_rw = 4'b1111; addr_rw = 9'd5; wd_in_rw = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if ({a_rd_valid_rw, a_rd_out_rw, a_rd_valid_r} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL mask_wr1: got %b/%h/%b expected 1/00000000/0", a_rd_valid_rw, a_rd_out_rw, a_rd_valid_r);
    end
    w_mask_rw = 4'b0010; wd_in_rw = 32'h0000_1100;
    tick();
    n_vec++;
    if ({a_rd_valid_rw, a_rd_out_rw, b_rd_valid_rw, b_rd_out_rw} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL mask_wr2_readfirst: got a=%b/%h b=%b/%h expected a=1/deadbeef b=1/00000000",
               a_rd_valid_rw, a_rd_out_rw, b_rd_valid_rw, b_rd_out_rw);
    end
    idle();
    ce_r = 1'b1; addr_r = 9'd5;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, b_rd_valid_rw, b_rd_out_rw} !==
        {1'b1, 32'hDEAD_11EF, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL mask_read: got a_r=%b/%h a_rw=%b/%h b_rw=%b/%h expected 1/dead11ef 0/deadbeef 1/deadbeef",
               a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, b_rd_valid_rw, b_rd_out_rw);
    end
    idle();
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, b_rd_valid_r, b_rd_out_r, b_rd_valid_rw} !==
        {1'b0, 32'hDEAD_11EF, 1'b1, 32'hDEAD_11EF, 1'b0}) begin
      n_err++;
      $display("FAIL mask_hold_lat2: got a_r=%b/%h b_r=%b/%h b_rw_v=%b expected 0/dead11ef 1/dead11ef 0",
               a_rd_valid_r, a_rd_out_r, b_rd_valid_r, b_rd_out_r, b_rd_valid_rw);
    end
  endtask

  task automatic test_bypass();
    ce_rw = 1'b1; we_rw = 1'b1; w_mask_rw = 4'hF; addr_rw = 9'd7; wd_in_rw = 32'hA5A5_A5A5;
    ce_r = 1'b1; addr_r = 9'd7;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, a_collision} !==
        {1'b1, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL bypass_a: got %b/%h %b/%h col=%b expected 1/a5a5a5a5 1/00000000 col=1",
               a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, a_collision);
    end
    n_vec++;
    if ({b_rd_valid_r, b_rd_valid_rw, b_collision} !== 3'b001) begin
      n_err++;
      $display("FAIL bypass_b_edge1: got %b expected 001", {b_rd_valid_r, b_rd_valid_rw, b_collision});
    end
    w_mask_rw = 4'b0001; wd_in_rw = 32'h0000_00FF;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, a_collision} !==
        {1'b1, 32'hA5A5_A5FF, 1'b1, 32'hA5A5_A5A5, 1'b1}) begin
      n_err++;
      $display("FAIL bypass_partial_a: got %b/%h %b/%h col=%b expected 1/a5a5a5ff 1/a5a5a5a5 col=1",
               a_rd_valid_r, a_rd_out_r, a_rd_valid_rw, a_rd_out_rw, a_collision);
    end
    n_vec++;
    if ({b_rd_valid_r, b_rd_out_r, b_rd_valid_rw, b_rd_out_rw, b_collision} !==
        {1'b1, 32'h0, 1'b1, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL nobypass_b: got %b/%h %b/%h col=%b expected 1/00000000 1/00000000 col=1",
               b_rd_valid_r, b_rd_out_r, b_rd_valid_rw, b_rd_out_rw, b_collision);
    end
    idle();
    tick();
    n_vec++;
    if ({a_collision, a_rd_valid_r, a_rd_valid_rw, b_collision} !== 4'b0000) begin
      n_err++;
      $display("FAIL collision_pulse: got %b expected 0000", {a_collision, a_rd_valid_r, a_rd_valid_rw, b_collision});
    end
    n_vec++;
    if ({b_rd_valid_r, b_rd_out_r, b_rd_valid_rw, b_rd_out_rw} !== {1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5}) begin
      n_err++;
      $display("FAIL nobypass_partial_b: got %b/%h %b/%h expected 1/a5a5a5a5 1/a5a5a5a5",
               b_rd_valid_r, b_rd_out_r, b_rd_valid_rw, b_rd_out_rw);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [32:0] exp_a [5];
    logic [32:0] exp_b [5];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      ce_rw = 1'b1; we_rw = 1'b1; w_mask_rw = 4'hF; addr_rw = 9'(i + 1); wd_in_rw = words[i];
      tick();
    end
    idle();
    tick(); tick();
    exp_a[0] = {1'b1, 32'h1111_1111}; exp_b[0] = {1'b0, 32'hA5A5_A5A5};
    exp_a[1] = {1'b1, 32'h2222_2222}; exp_b[1] = {1'b1, 32'h1111_1111};
    exp_a[2] = {1'b1, 32'h3333_3333}; exp_b[2] = {1'b1, 32'h2222_2222};
    exp_a[3] = {1'b0, 32'h3333_3333}; exp_b[3] = {1'b1, 32'h3333_3333};
    exp_a[4] = {1'b0, 32'h3333_3333}; exp_b[4] = {1'b0, 32'h3333_3333};
    for (int i = 0; i < 5; i++) begin
      ce_r = (i < 3); addr_r = 9'(i + 1);
      tick();
      n_vec++;
      if ({a_rd_valid_r, a_rd_out_r} !== exp_a[i] || {b_rd_valid_r, b_rd_out_r} !== exp_b[i]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got a=%b/%h b=%b/%h expected a=%h b=%h",
                 i, a_rd_valid_r, a_rd_out_r, b_rd_valid_r, b_rd_out_r, exp_a[i], exp_b[i]);
      end
    end
    idle();
  endtask

  task automatic test_oob();
    ce_r = 1'b1; addr_r = 9'd400;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_oob_err, b_rd_valid_r, b_rd_out_r, b_oob_err} !==
        {1'b1, 32'h0, 1'b1, 1'b0, 32'h3333_3333, 1'b1}) begin
      n_err++;
      $display("FAIL oob_read: got a=%b/%h/%b b=%b/%h/%b expected a=1/00000000/1 b=0/33333333/1",
               a_rd_valid_r, a_rd_out_r, a_oob_err, b_rd_valid_r, b_rd_out_r, b_oob_err);
    end
    idle();
    tick();
    n_vec++;
    if ({b_rd_valid_r, b_rd_out_r} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL oob_read_b: got %b/%h expected 1/00000000", b_rd_valid_r, b_rd_out_r);
    end
    repeat (4) tick();
    n_vec++;
    if ({a_oob_err, b_oob_err, a_rd_valid_r, b_rd_valid_r} !== 4'b1100) begin
      n_err++;
      $display("FAIL oob_sticky: got %b expected 1100", {a_oob_err, b_oob_err, a_rd_valid_r, b_rd_valid_r});
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    int bad;
    ce_r = 1'b1; addr_r = 9'd3;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, b_rd_valid_r} !== {1'b1, 32'h3333_3333, 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset_read: got %b/%h/%b expected 1/33333333/0", a_rd_valid_r, a_rd_out_r, b_rd_valid_r);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_init_busy, a_oob_err, a_rd_out_rw,
         b_rd_valid_r, b_rd_out_r, b_init_busy, b_oob_err} !==
        {1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got a=%b/%h/%b/%b/%h b=%b/%h/%b/%b expected all zero with init_busy 1",
               a_rd_valid_r, a_rd_out_r, a_init_busy, a_oob_err, a_rd_out_rw,
               b_rd_valid_r, b_rd_out_r, b_init_busy, b_oob_err);
    end
    ce_rw = 1'b1; we_rw = 1'b1; w_mask_rw = 4'hF; addr_rw = 9'd3; wd_in_rw = 32'hFFFF_FFFF;
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (a_rd_valid_r | a_rd_valid_rw | b_rd_valid_r | b_rd_valid_rw | a_collision | b_collision) bad++;
    end
    n_vec++;
    if ({a_init_busy, b_init_busy} !== 2'b11) begin
      n_err++;
      $display("FAIL init_at_200: got %b expected 11", {a_init_busy, b_init_busy});
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n = 0;
    while (a_init_busy === 1'b1 && n < 2000) begin
      tick();
      n++;
      if (a_rd_valid_r | a_rd_valid_rw | b_rd_valid_r | b_rd_valid_rw | a_collision | b_collision) bad++;
    end
    idle();
    n_vec++;
    if (n !== 384) begin
      n_err++;
      $display("FAIL reinit_cycles: got %0d expected 384", n);
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reinit_valid_pulses: got %0d expected 0", bad);
    end
    ce_r = 1'b1; addr_r = 9'd3;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, a_oob_err} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL recleared_addr3: got %b/%h/%b expected 1/00000000/0", a_rd_valid_r, a_rd_out_r, a_oob_err);
    end
    addr_r = 9'd5;
    tick();
    n_vec++;
    if ({a_rd_valid_r, a_rd_out_r, b_rd_valid_r, b_rd_out_r} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL recleared_addr5: got a=%b/%h b=%b/%h expected 1/00000000 1/00000000",
               a_rd_valid_r, a_rd_out_r, b_rd_valid_r, b_rd_out_r);
    end
    idle();
    tick();
    n_vec++;
    if ({b_rd_valid_r, b_rd_out_r, a_rd_valid_r} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL recleared_b_tail: got %b/%h/%b expected 1/00000000/0", b_rd_valid_r, b_rd_out_r, a_rd_valid_r);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mask_write();
    test_bypass();
    test_back_to_back();
    test_oob();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
